// File: rtl/serial_magnitude_comparator.sv
`timescale 1ns/1ps
// serial_magnitude_comparator
//   Multi-cycle unsigned magnitude comparator. Operands are captured on an
//   accepted start, then one 2-bit slice per cycle (MSB first) goes through a
//   2-bit G/E/L compare. The slice results are folded into a registered verdict.
//
//   Optional build macro: SERIAL_CMP_EARLY_EXIT_EN
//     defined   : RUN ends on the first slice whose result differs from EQ
//     undefined : RUN always lasts WIDTH/2 cycles (fixed latency)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   a      in   WIDTH  operand A (unsigned), captured on accepted start
//   b      in   WIDTH  operand B (unsigned), captured on accepted start
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle pulse, G/E/L valid in this cycle
//   G      out  1      a >  b
//   E      out  1      a == b
//   L      out  1      a <  b
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             E,
    output logic             L
);

    localparam int unsigned SLICES = WIDTH / 2;
    localparam int unsigned CNT_W  = $clog2(SLICES + 1);

    // Operands are consumed two bits at a time, so the width must split evenly.
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
        $error("serial_magnitude_comparator: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cmp_t               acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               g_q, g_d;
    logic               e_q, e_d;
    logic               l_q, l_d;

    logic [1:0]         slice_a;
    logic [1:0]         slice_b;
    cmp_t               slice_res;
    cmp_t               acc_fold;
    logic               last_slice;
    logic               run_exit;

    // 2-bit compare stage on the current top slice
    always_comb begin
        slice_a   = a_sh_q[WIDTH-1 -: 2];
        slice_b   = b_sh_q[WIDTH-1 -: 2];
        slice_res = CMP_EQ;
        if (slice_a > slice_b) begin
            slice_res = CMP_GT;
        end else if (slice_a < slice_b) begin
            slice_res = CMP_LT;
        end
    end

    // A decided verdict from a more significant slice is never overridden.
    always_comb begin
        acc_fold   = (acc_q == CMP_EQ) ? slice_res : acc_q;
        last_slice = (cnt_q == CNT_W'(1));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        run_exit   = last_slice || (acc_fold != CMP_EQ);
`else
        run_exit   = last_slice;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cnt_d   = CNT_W'(SLICES);
                    acc_d   = CMP_EQ;
                    busy_d  = 1'b1;
                    // Drop the previous verdict so nothing stale shows while busy.
                    g_d     = 1'b0;
                    e_d     = 1'b0;
                    l_d     = 1'b0;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q << 2;
                b_sh_d = b_sh_q << 2;
                cnt_d  = cnt_q - CNT_W'(1);
                acc_d  = acc_fold;
                if (run_exit) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    g_d     = (acc_fold == CMP_GT);
                    e_d     = (acc_fold == CMP_EQ);
                    l_d     = (acc_fold == CMP_LT);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= CMP_EQ;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign G    = g_q;
    assign E    = e_q;
    assign L    = l_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
`timescale 1ns/1ps
// Testbench for serial_magnitude_comparator: a WIDTH=8 instance checked every
// cycle against a behavioural timing/verdict model, plus a WIDTH=2 instance
// swept over all operand pairs.
module tb_serial_magnitude_comparator;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0;
    logic [7:0] a     = '0;
    logic [7:0] b     = '0;
    logic       busy, done, G, E, L;

    logic       start2 = 1'b0;
    logic [1:0] a2     = '0;
    logic [1:0] b2     = '0;
    logic       busy2, done2, G2, E2, L2;

    int errors = 0;
    int checks = 0;

    serial_magnitude_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .G(G), .E(E), .L(L)
    );

    serial_magnitude_comparator #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .G(G2), .E(E2), .L(L2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Verdict as {G,E,L} from plain unsigned arithmetic
    function automatic logic [2:0] ref_gel(input int unsigned x, input int unsigned y);
        if (x > y)  return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    // Number of RUN cycles for an 8-bit compare
    function automatic int run_len8(input logic [7:0] x, input logic [7:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int k = 0; k < 4; k++) begin
            if (((x >> (6 - 2 * k)) & 8'd3) != ((y >> (6 - 2 * k)) & 8'd3)) return k + 1;
        end
        return 4;
`else
        return (x == y) ? 4 : 4;
`endif
    endfunction

    // Behavioural model: busy, remaining RUN cycles, done pulse and verdict
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    logic [2:0] m_gel  = 3'b000;
    logic [2:0] m_pend = 3'b000;
    int         m_rem  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_gel  = 3'b000;
            m_rem  = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                m_gel  = m_pend;
            end
        end else if (start) begin
            m_busy = 1'b1;
            m_rem  = run_len8(a, b);
            m_gel  = 3'b000;
            m_pend = ref_gel(32'(a), 32'(b));
        end
    end

    // Every cycle, the WIDTH=8 outputs must follow the model
    always @(negedge clk) begin
        check("cycle", 32'({busy, done, G, E, L}), 32'({m_busy, m_done, m_gel}));
    end

    // One operation on the WIDTH=8 instance; lat counts negedges from start until done.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit noise,
                        output int lat, output logic [2:0] gel, output logic busy1);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        gel   = 3'b000;
        busy1 = busy;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                gel = {G, E, L};
                break;
            end
            if (noise) begin
                start = 1'($urandom % 2);
                a     = 8'($urandom);
                b     = 8'($urandom);
            end
            @(negedge clk);
        end
        // Start raised in the DONE cycle must be ignored.
        start = noise ? 1'($urandom % 2) : 1'b0;
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [2:0] table2 [16] = '{3'b010, 3'b001, 3'b001, 3'b001,
                                3'b100, 3'b010, 3'b001, 3'b001,
                                3'b100, 3'b100, 3'b010, 3'b001,
                                3'b100, 3'b100, 3'b100, 3'b010};

    initial begin
        int         lat;
        int         ndone;
        logic [2:0] gel;
        logic       b1;
        logic [7:0] ra, rb;

        repeat (2) @(negedge clk);
        check("reset_outs", 32'({busy, done, G, E, L}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Equal zero operands
        run8(8'h00, 8'h00, 1'b0, lat, gel, b1);
        check("t1_busy", 32'(b1), 32'd1);
        check("t1_lat", 32'(lat), 32'd5);
        check("t1_gel", 32'(gel), 32'(3'b010));

        // Difference only in the last slice
        run8(8'hA5, 8'hA4, 1'b0, lat, gel, b1);
        check("t2_lat", 32'(lat), 32'd5);
        check("t2_gel", 32'(gel), 32'(3'b100));

        // Difference in the first slice
        run8(8'h3C, 8'hC3, 1'b0, lat, gel, b1);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        check("t3_lat", 32'(lat), 32'd2);
`else
        check("t3_lat", 32'(lat), 32'd5);
`endif
        check("t3_gel", 32'(gel), 32'(3'b001));

        // Second start during RUN is ignored
        start = 1'b1; a = 8'h10; b = 8'h01;
        @(negedge clk);
        start = 1'b1; a = 8'h00; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        gel   = 3'b000;
        repeat (12) begin
            if (done) begin
                ndone++;
                gel = {G, E, L};
            end
            @(negedge clk);
        end
        check("t4_ndone", 32'(ndone), 32'd1);
        check("t4_gel", 32'(gel), 32'(3'b100));

        // Reset in the middle of an operation
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("t5_reset_outs", 32'({busy, done, G, E, L}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t5_no_done", 32'(ndone), 32'd0);

        // Random operations with noise on start/a/b while busy
        for (int i = 0; i < 80; i++) begin
            ra = 8'($urandom);
            rb = ($urandom % 4 == 0) ? ra : 8'($urandom);
            if ($urandom % 3 == 0) rb = (ra & 8'hF0) | (rb & 8'h0F);
            run8(ra, rb, 1'b1, lat, gel, b1);
            check("rand_gel", 32'(gel), 32'(ref_gel(32'(ra), 32'(rb))));
            check("rand_lat", 32'(lat), 32'(run_len8(ra, rb) + 1));
            repeat ($urandom % 3) @(negedge clk);
        end

        // WIDTH=2 instance, all operand pairs
        for (int i = 0; i < 16; i++) begin
            start2 = 1'b1;
            a2     = 2'(i / 4);
            b2     = 2'(i % 4);
            @(negedge clk);
            start2 = 1'b0;
            lat    = 0;
            gel    = 3'b000;
            for (int k = 1; k <= 10; k++) begin
                if (done2) begin
                    lat = k;
                    gel = {G2, E2, L2};
                    break;
                end
                @(negedge clk);
            end
            check("w2_lat", 32'(lat), 32'd2);
            check("w2_table", 32'(gel), 32'(table2[i]));
            check("w2_model", 32'(gel), 32'(ref_gel(32'(i / 4), 32'(i % 4))));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
